// File: rtl/alu_arbiter.sv
//-----------------------------------------------------------------------------
// alu_arbiter
//
// Two-requester round-robin arbiter and sequencer for a shared registered
// 4-bit ALU. One operation is in flight at a time:
//   IDLE -> ISSUE -> CAPTURE -> RESP -> IDLE
// The winner's operands/opcode are latched on the accept edge and drive the
// ALU for the following cycles. The ALU's registered result is sampled in
// CAPTURE and returned to the owning requester in RESP.
//
// Optional feature macro: ALU_ARB_PERF_EN
//   When defined, grant_cnt0/grant_cnt1 ports exist and count accepted
//   requests per requester, wrapping modulo 2^CNT_W.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   reqN_valid/ready             request handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op      request operands and opcode
//   rspN_valid/ready             response handshake
//   rspN_data                    shared 6-bit signed result register
//   alu_a, alu_b, alu_op         operands/opcode driven to the ALU
//   alu_c                        registered ALU result
//   busy                         high whenever not IDLE
//   grant_cnt0/1                 accepted-request counters (perf build only)
//-----------------------------------------------------------------------------
module alu_arbiter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_a,
   input  logic [3:0]       req0_b,
   input  logic [1:0]       req0_op,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_a,
   input  logic [3:0]       req1_b,
   input  logic [1:0]       req1_op,
   output logic             rsp0_valid,
   input  logic             rsp0_ready,
   output logic [5:0]       rsp0_data,
   output logic             rsp1_valid,
   input  logic             rsp1_ready,
   output logic [5:0]       rsp1_data,
   output logic [3:0]       alu_a,
   output logic [3:0]       alu_b,
   output logic [1:0]       alu_op,
   input  logic [5:0]       alu_c,
   output logic             busy
`ifdef ALU_ARB_PERF_EN
   ,
   output logic [CNT_W-1:0] grant_cnt0,
   output logic [CNT_W-1:0] grant_cnt1
`endif
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ISSUE   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_RESP    = 2'd3;

   logic [1:0] state_q, state_d;
   logic       last_q, last_d;     // owner of the most recent grant (1 = req1)
   logic       owner_q, owner_d;   // owner of the operation in flight
   logic [3:0] a_q, a_d;
   logic [3:0] b_q, b_d;
   logic [1:0] op_q, op_d;
   logic [5:0] res_q, res_d;

   logic       gnt0;
   logic       gnt1;
   logic       rsp_taken;

   // Round-robin arbitration: on a tie the requester not granted last wins.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if ((state_q == ST_IDLE) && !rst) begin
         if (req0_valid && req1_valid) begin
            gnt0 = last_q;
            gnt1 = !last_q;
         end else begin
            gnt0 = req0_valid;
            gnt1 = req1_valid;
         end
      end else begin
         gnt0 = 1'b0;
         gnt1 = 1'b0;
      end
   end

   // Response completes when the current owner takes it.
   always_comb begin
      if (owner_q) begin
         rsp_taken = rsp1_ready;
      end else begin
         rsp_taken = rsp0_ready;
      end
   end

   // Next-state and datapath register update logic.
   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      a_d     = a_q;
      b_d     = b_q;
      op_d    = op_q;
      res_d   = res_q;
      case (state_q)
         ST_IDLE: begin
            if (gnt0 || gnt1) begin
               owner_d = gnt1;
               last_d  = gnt1;
               a_d     = gnt1 ? req1_a  : req0_a;
               b_d     = gnt1 ? req1_b  : req0_b;
               op_d    = gnt1 ? req1_op : req0_op;
               state_d = ST_ISSUE;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ISSUE: begin
            state_d = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            // ALU registered its result at the end of ISSUE.
            res_d   = alu_c;
            state_d = ST_RESP;
         end
         ST_RESP: begin
            if (rsp_taken) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset favours req0 (last grant = req1).
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         last_q  <= 1'b1;
         owner_q <= 1'b0;
         a_q     <= 4'd0;
         b_q     <= 4'd0;
         op_q    <= 2'd0;
         res_q   <= 6'd0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         a_q     <= a_d;
         b_q     <= b_d;
         op_q    <= op_d;
         res_q   <= res_d;
      end
   end

   // Outputs are forced to their reset values for as long as rst is high,
   // which also hides an aborted operation during the reset cycle itself.
   always_comb begin
      req0_ready = gnt0;
      req1_ready = gnt1;
      if (rst) begin
         rsp0_valid = 1'b0;
         rsp1_valid = 1'b0;
         rsp0_data  = 6'd0;
         rsp1_data  = 6'd0;
         alu_a      = 4'd0;
         alu_b      = 4'd0;
         alu_op     = 2'd0;
         busy       = 1'b0;
      end else begin
         rsp0_valid = (state_q == ST_RESP) && !owner_q;
         rsp1_valid = (state_q == ST_RESP) && owner_q;
         rsp0_data  = res_q;
         rsp1_data  = res_q;
         alu_a      = a_q;
         alu_b      = b_q;
         alu_op     = op_q;
         busy       = (state_q != ST_IDLE);
      end
   end

`ifdef ALU_ARB_PERF_EN
   logic [CNT_W-1:0] cnt0_q;
   logic [CNT_W-1:0] cnt1_q;

   // Per-requester accept counters, wrapping naturally at 2^CNT_W.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= {CNT_W{1'b0}};
         cnt1_q <= {CNT_W{1'b0}};
      end else begin
         if (gnt0) begin
            cnt0_q <= cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (gnt1) begin
            cnt1_q <= cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   // Counter outputs read zero while reset is held.
   always_comb begin
      if (rst) begin
         grant_cnt0 = {CNT_W{1'b0}};
         grant_cnt1 = {CNT_W{1'b0}};
      end else begin
         grant_cnt0 = cnt0_q;
         grant_cnt1 = cnt1_q;
      end
   end
`else
   // CNT_W only sizes the perf counters; keep it referenced in this build.
   if (CNT_W > 0) begin : g_cnt_w_unused
   end
`endif

endmodule
